instr_issue_queue: RTL and testbench
====================================

// Module: instr_issue_queue
// PURPOSE
//  Issue stage directly upstream of the microprocessor core. Buffers 32-bit instructions from a loader
//  (valid/ready), drops encodings with an invalid opcode, and presents one instruction per cycle on the
//  core's instruction input. Inserts NOP bubbles on empty queue or on read-after-write hazards against
//  recently issued destinations. Start/halt/drain control FSM; issue, bubble and drop counters.
// PARAMETERS
//  DEPTH      8          queue entries (power of 2, >=2)
//  HAZ_DEPTH  2          issued destinations tracked for RAW check (1..4)
//  NOP_INSTR  32'h0      word driven when no instruction issues (opcode 0 = invalid, core ignores)
//  CNT_W      16         width of statistic counters
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active high
//  start        in   1      IDLE->RUN request (single-cycle pulse)
//  halt         in   1      RUN->DRAIN request (single-cycle pulse)
//  in_instr     in   32     loader instruction: [5:0] opcode, [10:6] src1, [15:11] src2, [20:16] dst
//  in_valid     in   1      in_instr valid
//  in_ready     out  1      queue accepts this cycle
//  instr_out    out  32     registered instruction to core
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle pulse on DRAIN->IDLE
//  drop_err     out  1      one-cycle pulse when an invalid-opcode word is discarded
//  issue_cnt    out  CNT_W  real instructions issued (saturating)
//  bubble_cnt   out  CNT_W  NOPs issued while in RUN or DRAIN (saturating)
//  drop_cnt     out  CNT_W  invalid words discarded (saturating)
// BEHAVIOUR
//  Reset: state=IDLE, queue empty, hazard tracker cleared, instr_out=NOP_INSTR, in_ready=0, busy=0,
//   done=0, drop_err=0, all counters 0. Reset mid-operation discards the queue contents with no drain.
//  FSM IDLE: in_ready=!full (preload allowed); instr_out held at NOP_INSTR; start -> RUN.
//   RUN: in_ready=!full; issue every cycle; halt -> DRAIN (halt wins if start and halt are both high).
//   DRAIN: in_ready=0; keep issuing; when the queue is empty and no instruction issues this cycle,
//   go to IDLE and pulse done. start/halt are ignored in DRAIN. halt in IDLE is ignored.
//  Push: occurs on in_valid&&in_ready. If opcode is not in {1,3,5,7,9,10,11,12,13,14,15}, the word is
//   not stored; drop_err pulses next cycle and drop_cnt increments. in_ready never depends on in_valid.
//   Full: in_ready=0, even if a pop happens the same cycle. No bypass path.
//  Issue decision, made in RUN or DRAIN: head exists and no hazard -> instr_out<=head, pop,
//   issue_cnt++; otherwise instr_out<=NOP_INSTR, bubble_cnt++. Push and pop in the same cycle are legal.
//  Latency: a word accepted at edge E is issued no earlier than edge E+1 (queue empty, RUN, no hazard).
//  Hazard: tracker is a HAZ_DEPTH shift register of {valid,dst}. Each issue slot shifts in {1,dst}
//   for a real instruction and {0,x} for a bubble. Hazard = head src1 or src2 equals any valid tracked
//   dst. So a dependent instruction is separated from its producer by exactly HAZ_DEPTH bubbles.
//   dst==src of the same instruction is not a hazard. Register 0 is not special.
//  Tracker clears on IDLE entry. Counters saturate at all-ones and are cleared only by reset.
//  Pointers are log2(DEPTH) bits plus a wrap bit; full/empty come from the pointer compare only.
// STRUCTURE
//  Shared package mp_pkg: opcode localparams (OP_ADD=3, OP_SUB=15, OP_ABS=13, OP_INV=12, OP_MAX=7,
//   OP_MIN=1, OP_AVG=9, OP_NOT=10, OP_OR=14, OP_AND=11, OP_XOR=5), field bit ranges, function
//   is_valid_opcode, state encoding. The core's opcode checker also uses this package.
//  One sub-module: iq_fifo (DEPTH x 32 synchronous queue with push/pop/full/empty/head).
//  FSM, hazard tracker and counters stay in this module.
// TESTING
//  1 Preload in IDLE: 0x00051043 (ADD r1,r2->r5), then start -> issued at the edge after start;
//    issue_cnt=1; the following cycles give NOP and bubble_cnt increments.
//  2 RAW: 0x00051043 then 0x0006194F (SUB r5,r3->r6), RUN -> ADD, NOP, NOP, SUB; bubble_cnt=2.
//  3 Independent stream: 0x00051043, 0x000720C1 (MIN r3,r4->r7) -> back-to-back issue, no bubble.
//  4 Invalid opcode: push 0x00010002 -> not stored, drop_err pulse, drop_cnt=1; queue stays empty.
//  5 Full/wrap: push 8 words in IDLE -> in_ready=0; start, stream 20 independent words with in_valid
//    held high -> issue order matches push order; issue_cnt=20 after drain.
//  6 Halt/reset: halt with 3 queued -> in_ready=0, 3 issued, done pulses once, then IDLE.
//    Repeat the run with rst asserted mid-run -> instr_out=NOP and all counters 0 immediately.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared opcode, field and state definitions for the issue queue and
// the core's opcode checker.
package mp_pkg;

  localparam logic [5:0] OP_MIN = 6'd1;
  localparam logic [5:0] OP_ADD = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_MAX = 6'd7;
  localparam logic [5:0] OP_AVG = 6'd9;
  localparam logic [5:0] OP_NOT = 6'd10;
  localparam logic [5:0] OP_AND = 6'd11;
  localparam logic [5:0] OP_INV = 6'd12;
  localparam logic [5:0] OP_ABS = 6'd13;
  localparam logic [5:0] OP_OR  = 6'd14;
  localparam logic [5:0] OP_SUB = 6'd15;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 5;
  localparam int SR1_LSB = 6;
  localparam int SR1_MSB = 10;
  localparam int SR2_LSB = 11;
  localparam int SR2_MSB = 15;
  localparam int DST_LSB = 16;
  localparam int DST_MSB = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } iq_state_e;

  function automatic logic is_valid_opcode(input logic [5:0] op);
    return op inside {OP_MIN, OP_ADD, OP_XOR, OP_MAX,
                      OP_AVG, OP_NOT, OP_AND, OP_INV,
                      OP_ABS, OP_OR, OP_SUB};
  endfunction

endpackage

// File: rtl/instr_issue_queue_if.sv
// Loader handshake, control pulses and status/statistics bundle
// between the issue queue and its environment.
interface instr_issue_queue_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt;
  logic [31:0]      in_instr;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr_out;
  logic             busy;
  logic             done;
  logic             drop_err;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output start, halt, in_instr, in_valid,
    input  in_ready, instr_out, busy, done, drop_err,
    input  issue_cnt, bubble_cnt, drop_cnt
  );

  modport slave (
    input  start, halt, in_instr, in_valid,
    output in_ready, instr_out, busy, done, drop_err,
    output issue_cnt, bubble_cnt, drop_cnt
  );
endinterface

// File: rtl/iq_fifo.sv
// Circular instruction queue; wrap bit on each pointer separates
// full from empty.
module iq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr, rd;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign wr      = push_i && !full_o;
  assign rd      = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/instr_issue_queue.sv
// Issue stage: buffers loader words, drops bad opcodes, issues one
// word or a NOP bubble per cycle with RAW hazard stalls.
module instr_issue_queue
  import mp_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter int          HAZ_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0,
  parameter int          CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  instr_issue_queue_if.slave  bus
);
  iq_state_e state_q, state_d;

  logic [31:0]      head, instr_out_q;
  logic             full, empty;
  logic             push, valid_op, wr_en;
  logic             issuing, pop, hazard;
  logic             done_q, done_d, drop_err_q;
  logic [CNT_W-1:0] issue_cnt_q, bubble_cnt_q, drop_cnt_q;

  logic [HAZ_DEPTH-1:0]      hv_q, hv_d;
  logic [HAZ_DEPTH-1:0][4:0] hd_q, hd_d;

  assign bus.in_ready = !rst && !full && (state_q != ST_DRAIN);
  assign push     = bus.in_valid && bus.in_ready;
  assign valid_op = is_valid_opcode(bus.in_instr[OPC_MSB:OPC_LSB]);
  assign wr_en    = push && valid_op;
  assign issuing  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign pop      = issuing && !empty && !hazard;

  iq_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .pop_i   (pop),
    .data_i  (bus.in_instr),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (hv_q[i] &&
          ((hd_q[i] == head[SR1_MSB:SR1_LSB]) ||
           (hd_q[i] == head[SR2_MSB:SR2_LSB])))
        hazard = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (bus.halt) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Every issue slot shifts; bubbles enter as invalid entries.
  always_comb begin
    hv_d = hv_q;
    hd_d = hd_q;
    if (done_d) begin
      hv_d = '0;
    end else if (issuing) begin
      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        hv_d[i] = hv_q[i-1];
        hd_d[i] = hd_q[i-1];
      end
      hv_d[0] = pop;
      hd_d[0] = head[DST_MSB:DST_LSB];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_out_q  <= NOP_INSTR;
      done_q       <= 1'b0;
      drop_err_q   <= 1'b0;
      hv_q         <= '0;
      hd_q         <= '0;
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      drop_err_q  <= push && !valid_op;
      hv_q        <= hv_d;
      hd_q        <= hd_d;
      instr_out_q <= pop ? head : NOP_INSTR;
      if (pop && issue_cnt_q != '1)
        issue_cnt_q <= issue_cnt_q + 1'b1;
      if (issuing && !pop && bubble_cnt_q != '1)
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      if (push && !valid_op && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign bus.instr_out  = instr_out_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.drop_err   = drop_err_q;
  assign bus.issue_cnt  = issue_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: preload, RAW bubbles,
// streaming, drops, full/wrap, halt/drain and async reset.
module tb_instr_issue_queue;
  localparam logic [31:0] ADD = 32'h00051043;
  localparam logic [31:0] SUB = 32'h0006194F;
  localparam logic [31:0] MIN = 32'h000720C1;
  localparam logic [31:0] BAD = 32'h00010002;
  localparam logic [31:0] NOP = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0] w [20];
  int          pushed, issued;
  logic        accept, seen;

  instr_issue_queue_if #(.CNT_W(16)) bus ();

  instr_issue_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.start    = 1'b0;
    bus.halt     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] d);
    bus.in_instr = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 20; k++)
      w[k] = 32'd3 | (32'd1 << 6) | (32'd2 << 11) | (32'(3 + k) << 16);

    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out", bus.instr_out, NOP);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_issue", 32'(bus.issue_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(bus.in_ready), 32'd1);

    // 1: preload then start
    push_one(ADD);
    chk("t1_idle_out", bus.instr_out, NOP);
    pulse_start();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_out0", bus.instr_out, NOP);
    tick();
    chk("t1_add", bus.instr_out, ADD);
    chk("t1_icnt", 32'(bus.issue_cnt), 32'd1);
    chk("t1_bcnt0", 32'(bus.bubble_cnt), 32'd0);
    tick();
    chk("t1_nop", bus.instr_out, NOP);
    chk("t1_bcnt1", 32'(bus.bubble_cnt), 32'd1);

    // 2: RAW dependency gets two bubbles
    do_reset();
    push_one(ADD);
    push_one(SUB);
    pulse_start();
    tick();
    chk("t2_add", bus.instr_out, ADD);
    tick();
    chk("t2_nop1", bus.instr_out, NOP);
    tick();
    chk("t2_nop2", bus.instr_out, NOP);
    tick();
    chk("t2_sub", bus.instr_out, SUB);
    chk("t2_bcnt", 32'(bus.bubble_cnt), 32'd2);
    chk("t2_icnt", 32'(bus.issue_cnt), 32'd2);

    // 3: independent back-to-back
    do_reset();
    push_one(ADD);
    push_one(MIN);
    pulse_start();
    tick();
    chk("t3_add", bus.instr_out, ADD);
    tick();
    chk("t3_min", bus.instr_out, MIN);
    chk("t3_bcnt", 32'(bus.bubble_cnt), 32'd0);

    // 4: invalid opcode dropped
    do_reset();
    push_one(BAD);
    chk("t4_derr", 32'(bus.drop_err), 32'd1);
    chk("t4_dcnt", 32'(bus.drop_cnt), 32'd1);
    tick();
    chk("t4_derr_off", 32'(bus.drop_err), 32'd0);
    pulse_start();
    tick();
    chk("t4_empty", bus.instr_out, NOP);
    chk("t4_icnt", 32'(bus.issue_cnt), 32'd0);

    // 5: fill, then stream through with wrap
    do_reset();
    for (int k = 0; k < 8; k++) push_one(w[k]);
    chk("t5_full", 32'(bus.in_ready), 32'd0);
    pushed = 8;
    issued = 0;
    pulse_start();
    for (int c = 0; c < 200 && issued < 20; c++) begin
      bus.in_valid = (pushed < 20);
      bus.in_instr = w[pushed < 20 ? pushed : 19];
      accept = bus.in_valid && bus.in_ready;
      tick();
      if (accept) pushed++;
      if (bus.instr_out !== NOP) begin
        chk("t5_order", bus.instr_out, w[issued < 20 ? issued : 19]);
        issued++;
      end
    end
    bus.in_valid = 1'b0;
    chk("t5_n_issued", 32'(issued), 32'd20);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk("t5_done", 32'(seen), 32'd1);
    chk("t5_icnt", 32'(bus.issue_cnt), 32'd20);

    // 6: halt with three queued
    do_reset();
    for (int k = 0; k < 3; k++) push_one(w[k]);
    pulse_start();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk("t6_w0", bus.instr_out, w[0]);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t6_w1", bus.instr_out, w[1]);
    chk("t6_nodone1", 32'(bus.done), 32'd0);
    tick();
    chk("t6_w2", bus.instr_out, w[2]);
    chk("t6_nodone2", 32'(bus.done), 32'd0);
    tick();
    chk("t6_done", 32'(bus.done), 32'd1);
    chk("t6_idle", 32'(bus.busy), 32'd0);
    chk("t6_nop", bus.instr_out, NOP);
    tick();
    chk("t6_done_off", 32'(bus.done), 32'd0);
    chk("t6_icnt", 32'(bus.issue_cnt), 32'd3);

    // 6b: async reset mid-run discards the queue
    push_one(w[0]);
    push_one(w[1]);
    push_one(BAD);
    pulse_start();
    tick();
    chk("t6b_w0", bus.instr_out, w[0]);
    rst = 1'b1;
    #1;
    chk("t6b_out", bus.instr_out, NOP);
    chk("t6b_icnt", 32'(bus.issue_cnt), 32'd0);
    chk("t6b_bcnt", 32'(bus.bubble_cnt), 32'd0);
    chk("t6b_dcnt", 32'(bus.drop_cnt), 32'd0);
    chk("t6b_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    pulse_start();
    tick();
    chk("t6b_flushed", bus.instr_out, NOP);
    chk("t6b_icnt2", 32'(bus.issue_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
